// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter checker: FSM encodings, default widths
// and the counter mode encodings used by the model and bench.
package counter_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned MAX_SB_DELAY  = 4;
    localparam int unsigned WARM_W        = 3;

    localparam logic [1:0] MODO_UP    = 2'b00;
    localparam logic [1:0] MODO_DOWN  = 2'b01;
    localparam logic [1:0] MODO_DOWN3 = 2'b10;
    localparam logic [1:0] MODO_LOAD  = 2'b11;

endpackage

// File: rtl/counter_checker_delay_line.sv
// Fixed-depth shift register that realigns the model stream with the DUT;
// DEPTH=0 degenerates to a plain wire.
module counter_checker_delay_line #(
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 0
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset_L, clr};
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] stages [DEPTH];

            // Shifts every cycle; start clears it so stale samples never compare.
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    for (int i = 0; i < int'(DEPTH); i++) stages[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < int'(DEPTH); i++) stages[i] <= '0;
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) stages[i] <= stages[i-1];
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/counter_checker.sv
// Compares DUT counter outputs against a (optionally delayed) scoreboard stream,
// counting mismatches and latching the first failure for the end-of-run report.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned SB_DELAY = 0,
    parameter int unsigned ERRW     = 8,
    parameter int unsigned CYCW     = 16
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] dut_Q,
    input  logic             dut_rco,
    input  logic [WIDTH-1:0] sb_Q,
    input  logic             sb_rco,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERRW-1:0]  err_count,
    output logic [CYCW-1:0]  chk_cycles,
    output logic [CYCW-1:0]  first_err_cycle,
    output logic [WIDTH:0]   first_err_dut,
    output logic [WIDTH:0]   first_err_sb
);

    localparam int unsigned SW = WIDTH + 1;
    localparam state_t RUN_STATE = (SB_DELAY == 0) ? ST_CHECK : ST_WARMUP;
    localparam logic [WARM_W-1:0] WARM_LAST =
        WARM_W'((SB_DELAY == 0) ? 0 : SB_DELAY - 1);

    state_t            state, state_next;
    logic [WARM_W-1:0] warm_cnt;
    logic [SW-1:0]     dut_s, sb_s, sb_d;
    logic              do_cmp, miss;

    assign dut_s = {dut_rco, dut_Q};
    assign sb_s  = {sb_rco, sb_Q};

    counter_checker_delay_line #(
        .W     (SW),
        .DEPTH (SB_DELAY)
    ) u_delay (
        .clk     (clk),
        .reset_L (reset_L),
        .clr     (start),
        .din     (sb_s),
        .dout    (sb_d)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= ST_IDLE;
        else          state <= state_next;
    end

    // start always (re)launches a run and beats stop; no compare on start/stop edges.
    always_comb begin
        state_next = state;
        do_cmp     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = RUN_STATE;
            end
            ST_WARMUP: begin
                if (start)                      state_next = RUN_STATE;
                else if (stop)                  state_next = ST_DONE;
                else if (warm_cnt == WARM_LAST) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (start)     state_next = RUN_STATE;
                else if (stop) state_next = ST_DONE;
                else           do_cmp = 1'b1;
            end
            ST_DONE: begin
                if (start) state_next = RUN_STATE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign miss = do_cmp && (dut_s != sb_d);

    // Result registers: cleared by start, updated on compares, frozen in DONE.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            mismatch        <= 1'b0;
            err_count       <= '0;
            chk_cycles      <= '0;
            first_err_cycle <= '0;
            first_err_dut   <= '0;
            first_err_sb    <= '0;
            warm_cnt        <= '0;
        end else begin
            busy <= (state_next == ST_WARMUP) || (state_next == ST_CHECK);
            done <= (state_next == ST_DONE);
            pass <= (state_next == ST_DONE) && (err_count == '0);

            if (start || state != ST_WARMUP) warm_cnt <= '0;
            else                             warm_cnt <= warm_cnt + WARM_W'(1);

            if (start) begin
                mismatch        <= 1'b0;
                err_count       <= '0;
                chk_cycles      <= '0;
                first_err_cycle <= '0;
                first_err_dut   <= '0;
                first_err_sb    <= '0;
            end else begin
                mismatch <= miss;
                if (do_cmp && chk_cycles != '1)
                    chk_cycles <= chk_cycles + CYCW'(1);
                if (miss) begin
                    if (err_count != '1) err_count <= err_count + ERRW'(1);
                    if (err_count == '0) begin
                        first_err_cycle <= chk_cycles;
                        first_err_dut   <= dut_s;
                        first_err_sb    <= sb_d;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: a direct-compare instance and a
// two-cycle-delayed instance driven through hand-computed scenarios.
module tb_counter_checker;
    import counter_checker_pkg::*;

    logic        clk = 1'b0;
    logic        reset_L;

    logic        start, stop, dut_rco, sb_rco;
    logic [3:0]  dut_Q, sb_Q;
    logic        busy, done, pass, mismatch;
    logic [7:0]  err_count;
    logic [15:0] chk_cycles, first_err_cycle;
    logic [4:0]  first_err_dut, first_err_sb;

    logic        d2_start, d2_stop, d2_dut_rco, d2_sb_rco;
    logic [3:0]  d2_dut_Q, d2_sb_Q;
    logic        d2_busy, d2_done, d2_pass, d2_mismatch;
    logic [7:0]  d2_err_count;
    logic [15:0] d2_chk_cycles, d2_first_err_cycle;
    logic [4:0]  d2_first_err_dut, d2_first_err_sb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(4), .SB_DELAY(0), .ERRW(8), .CYCW(16)) u_dut0 (
        .clk(clk), .reset_L(reset_L), .start(start), .stop(stop),
        .dut_Q(dut_Q), .dut_rco(dut_rco), .sb_Q(sb_Q), .sb_rco(sb_rco),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
        .err_count(err_count), .chk_cycles(chk_cycles),
        .first_err_cycle(first_err_cycle), .first_err_dut(first_err_dut),
        .first_err_sb(first_err_sb)
    );

    counter_checker #(.WIDTH(4), .SB_DELAY(2), .ERRW(8), .CYCW(16)) u_dut2 (
        .clk(clk), .reset_L(reset_L), .start(d2_start), .stop(d2_stop),
        .dut_Q(d2_dut_Q), .dut_rco(d2_dut_rco), .sb_Q(d2_sb_Q), .sb_rco(d2_sb_rco),
        .busy(d2_busy), .done(d2_done), .pass(d2_pass), .mismatch(d2_mismatch),
        .err_count(d2_err_count), .chk_cycles(d2_chk_cycles),
        .first_err_cycle(d2_first_err_cycle), .first_err_dut(d2_first_err_dut),
        .first_err_sb(d2_first_err_sb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference up/down/load counter, used to build the matched streams.
    function automatic logic [3:0] model_step(input logic [1:0] modo, input logic [3:0] q,
                                              input logic [3:0] d);
        case (modo)
            MODO_UP:    return q + 4'd1;
            MODO_DOWN:  return q - 4'd1;
            MODO_DOWN3: return q - 4'd3;
            default:    return d;
        endcase
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},  {31'd0, busy},     32'd0);
        check({tag, "_done"},  {31'd0, done},     32'd0);
        check({tag, "_pass"},  {31'd0, pass},     32'd0);
        check({tag, "_mis"},   {31'd0, mismatch}, 32'd0);
        check({tag, "_err"},   {24'd0, err_count},  32'd0);
        check({tag, "_chk"},   {16'd0, chk_cycles}, 32'd0);
        check({tag, "_fec"},   {16'd0, first_err_cycle}, 32'd0);
        check({tag, "_fed"},   {27'd0, first_err_dut},   32'd0);
        check({tag, "_fes"},   {27'd0, first_err_sb},    32'd0);
        check({tag, "_d2busy"}, {31'd0, d2_busy},   32'd0);
        check({tag, "_d2done"}, {31'd0, d2_done},   32'd0);
        check({tag, "_d2err"},  {24'd0, d2_err_count},  32'd0);
        check({tag, "_d2chk"},  {16'd0, d2_chk_cycles}, 32'd0);
        check({tag, "_d2fes"},  {27'd0, d2_first_err_sb}, 32'd0);
    endtask

    initial begin
        logic [3:0] cnt;
        logic [3:0] v;

        reset_L = 1'b1;
        start = 0; stop = 0; dut_Q = 0; dut_rco = 0; sb_Q = 0; sb_rco = 0;
        d2_start = 0; d2_stop = 0; d2_dut_Q = 0; d2_dut_rco = 0; d2_sb_Q = 0; d2_sb_rco = 0;

        // Reset asserted between clock edges
        #2 reset_L = 1'b0;
        #1 check_cleared("reset");
        #5 reset_L = 1'b1;
        tick();

        // stop in IDLE is ignored
        stop = 1; tick(); stop = 0;
        check("idle_stop_done", {31'd0, done}, 32'd0);
        check("idle_stop_busy", {31'd0, busy}, 32'd0);

        // Matching streams across the 15->0 wrap
        start = 1; tick(); start = 0;
        check("t2_busy", {31'd0, busy}, 32'd1);
        cnt = 4'd8;
        for (int i = 0; i < 20; i++) begin
            dut_Q = cnt; sb_Q = cnt;
            dut_rco = (cnt == 4'hF); sb_rco = (cnt == 4'hF);
            tick();
            if (i == 9) check("t2_chk_mid", {16'd0, chk_cycles}, 32'd10);
            cnt = model_step(MODO_UP, cnt, 4'd0);
        end
        stop = 1; tick(); stop = 0;
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_busy_off", {31'd0, busy}, 32'd0);
        check("t2_pass", {31'd0, pass}, 32'd1);
        check("t2_err", {24'd0, err_count}, 32'd0);
        check("t2_chk", {16'd0, chk_cycles}, 32'd20);
        tick();
        check("t2_hold_chk", {16'd0, chk_cycles}, 32'd20);
        check("t2_hold_done", {31'd0, done}, 32'd1);

        // Single Q mismatch at compare 7
        start = 1; tick(); start = 0;
        check("t3_cleared_chk", {16'd0, chk_cycles}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            v = 4'(i);
            dut_Q = v; sb_Q = v; dut_rco = 0; sb_rco = 0;
            if (i == 7) begin dut_Q = 4'd5; sb_Q = 4'd6; end
            tick();
            if (i == 6) check("t3_mis_before", {31'd0, mismatch}, 32'd0);
            if (i == 7) check("t3_mis_pulse", {31'd0, mismatch}, 32'd1);
            if (i == 8) check("t3_mis_after", {31'd0, mismatch}, 32'd0);
        end
        stop = 1; tick(); stop = 0;
        check("t3_err", {24'd0, err_count}, 32'd1);
        check("t3_fec", {16'd0, first_err_cycle}, 32'd7);
        check("t3_fed", {27'd0, first_err_dut}, 32'h05);
        check("t3_fes", {27'd0, first_err_sb}, 32'h06);
        check("t3_pass", {31'd0, pass}, 32'd0);
        check("t3_done", {31'd0, done}, 32'd1);

        // start and stop together: start wins; rco-only mismatch
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        check("t4_busy", {31'd0, busy}, 32'd1);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_err_clr", {24'd0, err_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            dut_Q = 4'hF; sb_Q = 4'hF; sb_rco = 1; dut_rco = (i != 1);
            tick();
        end
        stop = 1; tick(); stop = 0;
        check("t4_err", {24'd0, err_count}, 32'd1);
        check("t4_fec", {16'd0, first_err_cycle}, 32'd1);
        check("t4_fed", {27'd0, first_err_dut}, 32'h0F);
        check("t4_fes", {27'd0, first_err_sb}, 32'h1F);
        check("t4_pass", {31'd0, pass}, 32'd0);

        // Error counter saturation
        start = 1; tick(); start = 0;
        for (int i = 0; i < 300; i++) begin
            dut_Q = 4'd0; dut_rco = 0; sb_Q = 4'd1; sb_rco = 0;
            tick();
            if (i == 253) check("t5_err_254", {24'd0, err_count}, 32'd254);
        end
        stop = 1; tick(); stop = 0;
        check("t5_err_sat", {24'd0, err_count}, 32'd255);
        check("t5_fec", {16'd0, first_err_cycle}, 32'd0);
        check("t5_chk", {16'd0, chk_cycles}, 32'd300);
        check("t5_fed", {27'd0, first_err_dut}, 32'h00);
        check("t5_fes", {27'd0, first_err_sb}, 32'h01);

        // Delayed instance: model stream two cycles ahead of the DUT
        d2_start = 1; tick(); d2_start = 0;
        check("t6_busy", {31'd0, d2_busy}, 32'd1);
        for (int k = 1; k <= 22; k++) begin
            d2_sb_Q  = 4'(k + 5);
            d2_dut_Q = 4'(k + 3);
            d2_sb_rco  = (d2_sb_Q == 4'hF);
            d2_dut_rco = (d2_dut_Q == 4'hF);
            tick();
            if (k == 2) check("t6_warm_chk", {16'd0, d2_chk_cycles}, 32'd0);
            if (k == 2) check("t6_warm_busy", {31'd0, d2_busy}, 32'd1);
            if (k == 3) check("t6_first_cmp", {16'd0, d2_chk_cycles}, 32'd1);
        end
        check("t6_err", {24'd0, d2_err_count}, 32'd0);
        check("t6_chk", {16'd0, d2_chk_cycles}, 32'd20);
        check("t6_mis", {31'd0, d2_mismatch}, 32'd0);

        // Reset mid-CHECK, between edges
        #4 reset_L = 1'b0;
        #1 check_cleared("t6_rst");
        #2 reset_L = 1'b1;
        tick();

        // stop during WARMUP: immediate verdict with no compares
        d2_start = 1; tick(); d2_start = 0;
        d2_stop = 1; tick(); d2_stop = 0;
        check("warm_stop_done", {31'd0, d2_done}, 32'd1);
        check("warm_stop_pass", {31'd0, d2_pass}, 32'd1);
        check("warm_stop_chk", {16'd0, d2_chk_cycles}, 32'd0);
        check("warm_stop_busy", {31'd0, d2_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
